// File: rtl/alu_pkg.sv
// alu_pkg: shared types and helpers for the execute-stage ALU.
//   alu_ctrl_e   - canonical ALU operations, encoded as {funct7b5, funct3}
//   exec_state_e - sequencer state (IDLE accepts ops, SHIFT runs the
//                  iterative shifter)
//   decode_ctrl  - folds the raw 4-bit control code onto alu_ctrl_e
//   is_shift_op  - true for SLL/SRL/SRA
package alu_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int SHAMT_W_DEF = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_ctrl_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } exec_state_e;

    // funct7b5 only matters for funct3 000 (add/sub) and 101 (srl/sra);
    // every other funct3 maps to the same op whatever bit 3 says.
    function automatic alu_ctrl_e decode_ctrl(input logic [3:0] ctrl);
        alu_ctrl_e op;
        case (ctrl[2:0])
            3'b000:  op = ctrl[3] ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ctrl[3] ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic is_shift_op(input alu_ctrl_e op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational datapath for the execute-stage ALU.
//   op_i        - decoded operation
//   a_i, b_i    - operands
//   result_o    - single-cycle result; for shift ops this is a_i, which is
//                 the correct answer only for a zero shift amount
//   step_op_i   - shift kind for the one-bit step
//   step_acc_i  - accumulator before the step
//   step_acc_o  - accumulator shifted by one bit
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  alu_ctrl_e         op_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [XLEN-1:0]   result_o,
    input  alu_ctrl_e         step_op_i,
    input  logic [XLEN-1:0]   step_acc_i,
    output logic [XLEN-1:0]   step_acc_o
);

    logic lt_signed;
    logic lt_unsigned;

    assign lt_signed   = $signed(a_i) < $signed(b_i);
    assign lt_unsigned = a_i < b_i;

    always_comb begin
        result_o = a_i;
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, lt_signed};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, lt_unsigned};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            default:  result_o = a_i;
        endcase
    end

    always_comb begin
        step_acc_o = step_acc_i;
        case (step_op_i)
            ALU_SLL: step_acc_o = {step_acc_i[XLEN-2:0], 1'b0};
            ALU_SRL: step_acc_o = {1'b0, step_acc_i[XLEN-1:1]};
            ALU_SRA: step_acc_o = {step_acc_i[XLEN-1], step_acc_i[XLEN-1:1]};
            default: step_acc_o = step_acc_i;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with valid/ready on both sides.
//   clk, rst          - rising-edge clock, async active-high reset
//   in_valid/in_ready - operation handshake (alu_control, src_a, src_b)
//   flush             - synchronous kill of in-flight op and pending result
//   out_valid/out_ready, out_result, out_zero - registered result handshake
//   dbg_state_o       - current sequencer state
//
// Handshake: a transfer happens on an edge where valid && ready are both
// high; valid never depends on ready, and the result holds stable while
// out_valid && !out_ready.
module alu_exec
    import alu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_control,
    input  logic [XLEN-1:0]    src_a,
    input  logic [XLEN-1:0]    src_b,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_result,
    output logic               out_zero,
    output exec_state_e        dbg_state_o
);

    exec_state_e          state_q, state_d;
    alu_ctrl_e            op_q, op_d;
    logic [XLEN-1:0]      acc_q, acc_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic [XLEN-1:0]      result_q, result_d;
    logic                 zero_q, zero_d;

    alu_ctrl_e            op_in;
    logic [XLEN-1:0]      core_result;
    logic [XLEN-1:0]      step_acc;
    logic [SHAMT_W-1:0]   shamt;
    logic                 slot_free;
    logic                 accept;

    assign op_in     = decode_ctrl(alu_control);
    assign shamt     = src_b[SHAMT_W-1:0];
    assign slot_free = !valid_q || out_ready;
    // Gating with rst makes in_ready fall the moment reset is asserted.
    assign in_ready  = !rst && (state_q == IDLE) && slot_free;
    assign accept    = in_valid && in_ready;

    alu_core #(.XLEN(XLEN)) u_core (
        .op_i       (op_in),
        .a_i        (src_a),
        .b_i        (src_b),
        .result_o   (core_result),
        .step_op_i  (op_q),
        .step_acc_i (acc_q),
        .step_acc_o (step_acc)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        // A drained result clears unless a new one lands on the same edge.
        valid_d  = valid_q && !out_ready;

        if (flush) begin
            valid_d = 1'b0;
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_shift_op(op_in) && (shamt != '0)) begin
                            op_d    = op_in;
                            acc_d   = src_a;
                            cnt_d   = shamt;
                            state_d = SHIFT;
                        end else begin
                            result_d = core_result;
                            zero_d   = (core_result == '0);
                            valid_d  = 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (cnt_q != '0) begin
                        acc_d = step_acc;
                        cnt_d = cnt_q - SHAMT_W'(1);
                    end else if (slot_free) begin
                        result_d = acc_q;
                        zero_d   = (acc_q == '0);
                        valid_d  = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= ALU_ADD;
            acc_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_result  = result_q;
    assign out_zero    = zero_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    exec_state_e dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    alu_exec #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .dbg_state_o (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one op for a single edge.
    task automatic issue(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        alu_control = ctrl;
        src_a       = a;
        src_b       = b;
        in_valid    = 1'b1;
        step();
        in_valid    = 1'b0;
    endtask

    // Count edges until out_valid, bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 64) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int rises;

        rst = 1'b1; in_valid = 1'b0; alu_control = 4'h0;
        src_a = '0; src_b = '0; flush = 1'b0; out_ready = 1'b1;
        #2;
        check("rst_valid",  32'(out_valid), 32'd0);
        check("rst_result", out_result, 32'd0);
        check("rst_zero",   32'(out_zero), 32'd0);
        check("rst_state",  32'(dbg_state), 32'(IDLE));
        check("rst_ready",  32'(in_ready), 32'd0);
        #10 rst = 1'b0;
        step();
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // add 5+7
        issue(4'b0000, 32'd5, 32'd7);
        check("add_valid",  32'(out_valid), 32'd1);
        check("add_result", out_result, 32'd12);
        check("add_zero",   32'(out_zero), 32'd0);
        check("add_ready",  32'(in_ready), 32'd1);

        // back-to-back single-cycle ops
        issue(4'b1000, 32'h1234, 32'h1234);
        check("sub_result", out_result, 32'd0);
        check("sub_zero",   32'(out_zero), 32'd1);
        check("sub_valid",  32'(out_valid), 32'd1);
        issue(4'b0010, 32'hFFFF_FFFF, 32'd1);
        check("slt_result", out_result, 32'd1);
        check("slt_zero",   32'(out_zero), 32'd0);
        issue(4'b0011, 32'hFFFF_FFFF, 32'd1);
        check("sltu_result", out_result, 32'd0);
        issue(4'b1100, 32'hA5A5_0000, 32'h0F0F_FFFF);
        check("xor_alias", out_result, 32'hAAAA_FFFF);
        issue(4'b0110, 32'h0000_F000, 32'h0000_000F);
        check("or_result", out_result, 32'h0000_F00F);
        issue(4'b1111, 32'hFF00_FF00, 32'h0F0F_0F0F);
        check("and_alias", out_result, 32'h0F00_0F00);
        issue(4'b0000, 32'hFFFF_FFFF, 32'd2);
        check("add_wrap", out_result, 32'd1);
        issue(4'b1001, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
        check("sll_shamt0", out_result, 32'hDEAD_BEEF);
        check("sll0_valid", 32'(out_valid), 32'd1);
        step();
        check("drain_valid", 32'(out_valid), 32'd0);

        // sra by 4, explicit per-cycle checks
        issue(4'b1101, 32'h8000_0000, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("sra_wait_valid", 32'(out_valid), 32'd0);
            check("sra_wait_ready", 32'(in_ready), 32'd0);
            check("sra_wait_state", 32'(dbg_state), 32'(SHIFT));
            step();
        end
        check("sra_wait_valid4", 32'(out_valid), 32'd0);
        step();
        check("sra_valid",  32'(out_valid), 32'd1);
        check("sra_result", out_result, 32'hF800_0000);
        check("sra_ready",  32'(in_ready), 32'd1);

        // srl by 4
        issue(4'b0101, 32'h8000_0000, 32'd4);
        wait_valid(n);
        check("srl_latency", 32'(n), 32'd5);
        check("srl_result", out_result, 32'h0800_0000);

        // sll by 4
        issue(4'b0001, 32'h0000_0003, 32'd4);
        wait_valid(n);
        check("sll_latency", 32'(n), 32'd5);
        check("sll_result", out_result, 32'h0000_0030);
        step();

        // back-pressure
        out_ready = 1'b0;
        issue(4'b0000, 32'd4, 32'd5);
        check("bp_result", out_result, 32'd9);
        check("bp_ready",  32'(in_ready), 32'd0);
        alu_control = 4'b0100; src_a = 32'hF0; src_b = 32'hFF; in_valid = 1'b1;
        step();
        check("bp_hold_result", out_result, 32'd9);
        check("bp_hold_valid",  32'(out_valid), 32'd1);
        out_ready = 1'b1;
        #1;
        check("bp_ready_up", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_swap_valid",  32'(out_valid), 32'd1);
        check("bp_swap_result", out_result, 32'h0000_000F);
        step();
        check("bp_drained", 32'(out_valid), 32'd0);

        // flush mid-shift
        issue(4'b0001, 32'd1, 32'd20);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_state", 32'(dbg_state), 32'(IDLE));
        check("flush_ready", 32'(in_ready), 32'd1);
        rises = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (out_valid) rises++;
        end
        check("flush_no_result", 32'(rises), 32'd0);
        issue(4'b0000, 32'd2, 32'd2);
        check("post_flush_add", out_result, 32'd4);
        check("post_flush_valid", 32'(out_valid), 32'd1);
        step();

        // async reset mid-shift
        issue(4'b0101, 32'hFFFF_FFFF, 32'd31);
        step();
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check("arst_valid",  32'(out_valid), 32'd0);
        check("arst_ready",  32'(in_ready), 32'd0);
        check("arst_state",  32'(dbg_state), 32'(IDLE));
        check("arst_result", out_result, 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("arst_rel_ready", 32'(in_ready), 32'd1);
        issue(4'b0000, 32'd10, 32'hFFFF_FFF6);
        check("arst_add_valid",  32'(out_valid), 32'd1);
        check("arst_add_result", out_result, 32'd0);
        check("arst_add_zero",   32'(out_zero), 32'd1);
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) rises++;
        end
        check("arst_no_late_result", 32'(rises), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
Execute-stage ALU that consumes the 4-bit ALU control code {funct7b5, funct3} from the ALU decoder, together with two operands, and produces a registered result plus a zero flag.
- Single-cycle ops (add/sub/logic/compare) complete one edge after acceptance.
- Shifts run on an iterative 1-bit-per-cycle shifter to save area.
- Valid/ready handshakes on both sides, so the core stalls cleanly on multi-cycle shifts.

Parameters:
XLEN, 32, operand/result width
SHAMT_W, 5, shift-amount width (log2 XLEN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operation presented
in_ready  out  1  block can accept an operation this cycle
alu_control  in  4  {funct7b5, funct3} ALU control code
src_a  in  XLEN  operand A
src_b  in  XLEN  operand B; shift amount = src_b[SHAMT_W-1:0]
flush  in  1  synchronous kill of in-flight op and pending result
out_valid  out  1  result register holds a valid result
out_ready  in  1  consumer takes result this cycle
out_result  out  XLEN  registered result
out_zero  out  1  registered (out_result == 0)

Behaviour:
- Reset (async, active-high): out_valid=0, out_result=0, out_zero=0, FSM=IDLE, internal accumulator and counter=0.
- Reset asserted mid-shift aborts the operation immediately; nothing is produced.
- Control decode:
  - 0000 add, 1000 sub.
  - 0001 sll.
  - 0010 slt (signed), 0011 sltu (unsigned); result is 1 or 0 zero-extended.
  - 0100 xor, 0110 or, 0111 and.
  - 0101 srl, 1101 sra.
  - Bit 3 is ignored for funct3 values other than 000 and 101 (e.g. 1100 = xor, 1001 = sll).
- Arithmetic wraps modulo 2^XLEN; no overflow or carry outputs.
- Handshake:
  - in_ready = (FSM==IDLE) && (!out_valid || out_ready).
  - An op is accepted on an edge with in_valid && in_ready.
  - The result slot frees on an edge with out_valid && out_ready.
  - out_result and out_zero hold stable while out_valid && !out_ready.
- Non-shift op, or shift with shamt==0: at the accept edge, write out_result/out_zero and set out_valid=1 (latency 1). Shamt 0 returns src_a.
- Shift with shamt!=0: at the accept edge, acc<=src_a, cnt<=shamt, FSM->SHIFT.
- FSM states:
  - IDLE -> SHIFT: on accept of a shift with shamt!=0.
  - SHIFT, cnt!=0: shift acc by one bit per edge (sll: zero fill; srl: zero fill; sra: fill with acc[XLEN-1]) and decrement cnt.
  - SHIFT, cnt==0 with (!out_valid || out_ready): write acc to out_result and out_zero, set out_valid=1, FSM->IDLE.
  - SHIFT, cnt==0 with out_valid && !out_ready: hold acc; stay in SHIFT.
- Shift latency from accept edge to out_valid is shamt+1 edges without back-pressure.
- out_valid clears on an edge with out_ready && out_valid unless a new result is written on the same edge. A simultaneous drain and write yields out_valid=1 with the new data.
- Back-to-back: single-cycle ops sustain 1 op/cycle when out_ready is held high.
- flush (priority over everything except rst): on the edge, out_valid<=0 and FSM->IDLE; any accept that edge is discarded. in_ready is still computed as above.

Decomposition:
- Package alu_pkg:
  - enum alu_ctrl_e for the ten control codes (ADD=4'b0000, SUB=4'b1000, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND).
  - enum exec_state_e {IDLE, SHIFT}.
  - Constant XLEN_DEF=32.
- Sub-module alu_core: purely combinational single-cycle ops (add/sub/slt/sltu/logic) plus the one-bit shift step function. alu_exec owns the FSM, counter, accumulator and output register.

Test Plan:
- Add: ctrl 0000, A=5, B=7, out_ready=1 -> next edge out_valid=1, out_result=12, out_zero=0; in_ready stays 1.
- Sub to zero, then compares:
  - ctrl 1000, A=B=0x1234 -> out_result=0, out_zero=1.
  - ctrl 0010, A=0xFFFFFFFF, B=1 -> 1.
  - ctrl 0011, same operands -> 0.
- Arithmetic shift: ctrl 1101, A=0x80000000, B=4 -> in_ready=0 for 4 cycles; out_valid rises 5 edges after accept with out_result=0xF8000000. ctrl 0101 with the same operands -> 0x08000000.
- Back-pressure: out_ready=0 after an add result (9) -> in_ready=0, out_result held at 9. Raise out_ready for one cycle with a queued xor (A=0xF0, B=0xFF) -> drain and new write on the same edge; out_valid stays 1 with out_result=0x0F.
- Flush mid-shift: sll A=1, B=20, assert flush at cycle 3 -> out_valid never rises, FSM IDLE, in_ready=1 next cycle. A following add 2+2 returns 4.
- Async reset mid-shift: assert rst between clock edges during srl by 31 -> out_valid=0 and in_ready=0 immediately. After release, in_ready=1 and a new add completes normally.
